// File: rtl/iter_stream_if.sv
//============================================================================
// Module      : iter_stream_if
// Description : Valid/ready index stream carrying an index and a last-beat
//               flag from the iterator (master) to its consumer (slave).
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

interface iter_stream_if #(
    parameter int WIDTH = 4
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;
    logic             last;

    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );
endinterface

`default_nettype wire

// File: rtl/iter_stream.sv
//============================================================================
// Module      : iter_stream
// Description : Producer-side index iterator. A start pulse launches a
//               valid/ready stream of indices 0..MAX_VALUE, one beat per
//               cycle when the consumer is ready; the final beat carries
//               last, and done pulses the cycle after it is accepted.
//               Optional macro ITER_STREAM_ABORT_EN adds an abort input
//               that terminates a running sequence early.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module iter_stream #(
    parameter int MAX_VALUE = 15
) (
    input  wire logic        clk,
    input  wire logic        reset,     // asynchronous, active-low
    input  wire logic        start,
`ifdef ITER_STREAM_ABORT_EN
    input  wire logic        abort,
`endif
    output logic             busy,
    output logic             done,
    iter_stream_if.master    strm
);

    // Index width; a single-value sweep still needs one bit.
    localparam int WIDTH = (MAX_VALUE < 1) ? 1 : $clog2(MAX_VALUE + 1);
    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX_VALUE);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_last;
    logic             w_abort;

`ifdef ITER_STREAM_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // The stream is valid exactly while running, so valid and last come
    // from registered state only and never look at ready.
    assign w_last      = (r_state == S_RUN) && (r_data == c_MAX);
    assign strm.valid  = (r_state == S_RUN);
    assign strm.data   = r_data;
    assign strm.last   = w_last;
    assign busy        = (r_state == S_RUN);
    assign done        = r_done;

    // State, index counter and done pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic: start only in IDLE; in RUN the index advances on
    // each accepted beat, and the final beat (or abort) returns to IDLE
    // with the counter cleared and a done pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_data_nxt  = '0;
                end
            end
            S_RUN: begin
                if (w_abort || (strm.ready && w_last)) begin
                    w_state_nxt = S_IDLE;
                    w_data_nxt  = '0;
                    w_done_nxt  = 1'b1;
                end else if (strm.ready) begin
                    w_data_nxt  = r_data + WIDTH'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_data_nxt  = '0;
            end
        endcase
    end

`ifndef SYNTHESIS
    // The index stays inside the sweep range.
    a_range: assert property (@(posedge clk) disable iff (!reset)
        r_data <= c_MAX);

    // A stalled beat is held unchanged until accepted (abort excepted).
    a_hold: assert property (@(posedge clk) disable iff (!reset)
        (strm.valid && !strm.ready && !w_abort) |=>
            (strm.valid && $stable(strm.data)));

    // done only ever follows a running cycle.
    a_done: assert property (@(posedge clk) disable iff (!reset)
        r_done |-> (r_state == S_IDLE));
`endif

endmodule

`default_nettype wire

// File: tb/tb_iter_stream.sv
//============================================================================
// Module      : tb_iter_stream
// Description : Self-checking bench for iter_stream: a per-cycle vector
//               table, a handshake scoreboard, and hand-written sequences
//               for reset, single-beat and abort corner cases.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_iter_stream;

    logic clk;
    logic reset_n;
    logic start3, ready3, start0, ready0;
    logic busy3, done3, busy0, done0;
`ifdef ITER_STREAM_ABORT_EN
    logic abort3;
    logic abort0;
`endif

    int checks = 0;
    int errors = 0;

    // Scoreboard model state
    int   q[$];
    logic m_run  = 1'b0;
    logic m_done = 1'b0;

    iter_stream_if #(.WIDTH(2)) if3 ();
    iter_stream_if #(.WIDTH(1)) if0 ();

    assign if3.ready = ready3;
    assign if0.ready = ready0;

    iter_stream #(.MAX_VALUE(3)) dut3 (
        .clk   (clk),
        .reset (reset_n),
        .start (start3),
`ifdef ITER_STREAM_ABORT_EN
        .abort (abort3),
`endif
        .busy  (busy3),
        .done  (done3),
        .strm  (if3.master)
    );

    iter_stream #(.MAX_VALUE(0)) dut0 (
        .clk   (clk),
        .reset (reset_n),
        .start (start0),
`ifdef ITER_STREAM_ABORT_EN
        .abort (abort0),
`endif
        .busy  (busy0),
        .done  (done0),
        .strm  (if0.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_clear();
        q.delete();
        m_run  = 1'b0;
        m_done = 1'b0;
    endtask

    // One cycle: drive inputs after the rising edge, sample at the falling
    // edge, and run the scoreboard against the bench's own model.
    task automatic step(input int sel, input logic st, input logic rd,
                        output logic v, output logic b, output int d,
                        output logic l, output logic dn);
        int   mx;
        int   exp;
        logic was_run;
        @(posedge clk);
        #1;
        if (sel == 3) begin
            start3 = st; ready3 = rd; start0 = 1'b0; ready0 = 1'b0;
        end else begin
            start0 = st; ready0 = rd; start3 = 1'b0; ready3 = 1'b0;
        end
        @(negedge clk);
        mx = (sel == 3) ? 3 : 0;
        if (sel == 3) begin
            v = if3.valid; b = busy3; d = int'(if3.data); l = if3.last; dn = done3;
        end else begin
            v = if0.valid; b = busy0; d = int'(if0.data); l = if0.last; dn = done0;
        end
        check("sb_valid", v, m_run);
        check("sb_done", dn, m_done);
        m_done  = 1'b0;
        was_run = m_run;
        if (m_run && rd) begin
            if (q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                exp = q.pop_front();
                check("sb_data", d, exp);
                check("sb_last", l, (exp == mx));
                if (exp == mx) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
        if (!was_run && st) begin
            for (int i = 0; i <= mx; i++) q.push_back(i);
            m_run = 1'b1;
        end
    endtask

    typedef struct {
        logic start;
        logic ready;
        logic valid;
        logic busy;
        int   data;
        logic last;
        logic done;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic v, b, l, dn;
        int   d;

        // start ready | valid busy data last done  (MAX_VALUE = 3)
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 2, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0};

        reset_n = 1'b0;
        start3 = 1'b0; ready3 = 1'b0; start0 = 1'b0; ready0 = 1'b0;
`ifdef ITER_STREAM_ABORT_EN
        abort3 = 1'b0; abort0 = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_valid", if3.valid, 0);
        check("rst_busy",  busy3, 0);
        check("rst_data",  if3.data, 0);
        check("rst_last",  if3.last, 0);
        check("rst_done",  done3, 0);
        check("rst_valid0", if0.valid, 0);
        reset_n = 1'b1;

        // Vector table: basic run, start held high, stalls, restart.
        for (int i = 0; i < 14; i++) begin
            step(3, vecs[i].start, vecs[i].ready, v, b, d, l, dn);
            check($sformatf("vec%0d_valid", i), v,  vecs[i].valid);
            check($sformatf("vec%0d_busy", i),  b,  vecs[i].busy);
            check($sformatf("vec%0d_data", i),  d,  vecs[i].data);
            check($sformatf("vec%0d_last", i),  l,  vecs[i].last);
            check($sformatf("vec%0d_done", i),  dn, vecs[i].done);
        end

        // Ready toggling 1,0,0,1,...: every index once, in order.
        step(3, 1'b1, 1'b1, v, b, d, l, dn);
        for (int i = 0; i < 16; i++) begin
            step(3, 1'b0, ((i % 3) == 0), v, b, d, l, dn);
        end
        repeat (4) step(3, 1'b0, 1'b1, v, b, d, l, dn);
        check("toggle_drained", q.size(), 0);

        // Random start/ready traffic through the scoreboard.
        for (int i = 0; i < 60; i++) begin
            step(3, 1'(($urandom % 4) == 0), 1'($urandom % 2), v, b, d, l, dn);
        end
        repeat (12) step(3, 1'b0, 1'b1, v, b, d, l, dn);
        check("rand_drained", q.size(), 0);

        // MAX_VALUE = 0: single beat, held through a stall.
        step(0, 1'b1, 1'b1, v, b, d, l, dn);
        step(0, 1'b0, 1'b0, v, b, d, l, dn);
        check("max0_valid", v, 1);
        check("max0_last", l, 1);
        check("max0_data", d, 0);
        step(0, 1'b0, 1'b1, v, b, d, l, dn);
        check("max0_hold_last", l, 1);
        step(0, 1'b0, 1'b1, v, b, d, l, dn);
        check("max0_done", dn, 1);
        check("max0_busy_off", b, 0);
        step(0, 1'b0, 1'b1, v, b, d, l, dn);
        check("max0_done_pulse", dn, 0);

        // Asynchronous reset while data == 2.
        step(3, 1'b1, 1'b1, v, b, d, l, dn);
        step(3, 1'b0, 1'b1, v, b, d, l, dn);
        step(3, 1'b0, 1'b1, v, b, d, l, dn);
        @(posedge clk);
        #1;
        ready3 = 1'b0;
        #2;
        check("pre_rst_data", if3.data, 2);
        reset_n = 1'b0;
        #1;
        check("arst_valid", if3.valid, 0);
        check("arst_busy",  busy3, 0);
        check("arst_data",  if3.data, 0);
        check("arst_last",  if3.last, 0);
        check("arst_done",  done3, 0);
        sb_clear();
        @(negedge clk);
        reset_n = 1'b1;
        step(3, 1'b0, 1'b1, v, b, d, l, dn);
        check("post_rst_nodone", dn, 0);
        step(3, 1'b0, 1'b1, v, b, d, l, dn);
        check("post_rst_idle", v, 0);
        step(3, 1'b1, 1'b1, v, b, d, l, dn);
        step(3, 1'b0, 1'b1, v, b, d, l, dn);
        check("restart_data", d, 0);
        repeat (5) step(3, 1'b0, 1'b1, v, b, d, l, dn);
        check("restart_drained", q.size(), 0);

`ifdef ITER_STREAM_ABORT_EN
        // Abort at data == 1 with ready low.
        step(3, 1'b1, 1'b1, v, b, d, l, dn);
        step(3, 1'b0, 1'b1, v, b, d, l, dn);
        @(posedge clk);
        #1;
        start3 = 1'b0; ready3 = 1'b0; abort3 = 1'b1;
        @(negedge clk);
        check("abort_pre_data", if3.data, 1);
        check("abort_pre_valid", if3.valid, 1);
        @(posedge clk);
        #1;
        abort3 = 1'b0;
        @(negedge clk);
        check("abort_valid", if3.valid, 0);
        check("abort_busy",  busy3, 0);
        check("abort_data",  if3.data, 0);
        check("abort_done",  done3, 1);
        sb_clear();
        step(3, 1'b0, 1'b1, v, b, d, l, dn);
        check("abort_done_pulse", dn, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
